instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/dlx_pkg.sv | 26 ++
 rtl/next_pc_calc.sv | 33 +++
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, ALU operations, fetch-stage state and defaults.
// Instruction words use big-endian bit numbering, so the opcode is word[0:5].
package dlx_pkg;

  localparam logic [0:31] ResetVectorDefault = 32'h0000_0000;

  localparam logic [0:5] OpJ    = 6'h02;
  localparam logic [0:5] OpJal  = 6'h03;
  localparam logic [0:5] OpBeqz = 6'h04;
  localparam logic [0:5] OpBnez = 6'h05;
  localparam logic [0:5] OpAddi = 6'h08;
  localparam logic [0:5] OpTrap = 6'h11;
  localparam logic [0:5] OpJr   = 6'h12;
  localparam logic [0:5] OpJalr = 6'h13;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt
  } alu_op_e;

  typedef enum logic [1:0] {StFetch, StHold, StHalt} fetch_state_e;

  function automatic logic [0:5] opcode_of(input logic [0:31] word);
    return word[0:5];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage. The PC is never masked, so the
// low alignment bits pass through the 32-bit modulo adds untouched.
module next_pc_calc (
  input  logic [0:31] pc,
  input  logic [0:25] offset,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_use_reg,
  input  logic        branch_taken,
  input  logic [0:31] jump_reg_val,
  output logic [0:31] pc_plus4,
  output logic [0:31] next_pc
);

  logic [0:31] off26_sext;
  logic [0:31] off16_sext;

  assign pc_plus4   = pc + 32'd4;
  assign off26_sext = {{6{offset[0]}}, offset};
  assign off16_sext = {{16{offset[10]}}, offset[10:25]};

  always_comb begin
    next_pc = pc_plus4;
    if (jump && jump_use_reg) begin
      next_pc = jump_reg_val;
    end else if (jump) begin
      next_pc = pc_plus4 + off26_sext;
    end else if (branch && branch_taken) begin
      next_pc = pc_plus4 + off16_sext;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word from imem, holds it for the datapath until
// retired, then advances the PC. Retiring a TRAP parks the stage until reset.
module instr_fetch
  import dlx_pkg::*;
#(
  parameter logic [0:31] RESET_VECTOR = ResetVectorDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  output logic [0:31] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [0:31] pc_out,
  output logic [0:31] pc_plus4,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JUMP_USE_REG,
  input  logic        branch_taken,
  input  logic [0:31] jump_reg_val,
  output logic        halted,
  output logic [0:31] retired_cnt
);

  fetch_state_e state_q, state_d;
  logic [0:31]  pc_q, pc_d;
  logic [0:31]  instr_q, instr_d;
  logic [0:31]  cnt_q, cnt_d;
  logic [0:31]  next_pc;
  logic [0:31]  pc_inc;

  next_pc_calc u_next_pc_calc (
    .pc           (pc_q),
    .offset       (instr_q[6:31]),
    .branch       (BRANCH),
    .jump         (JUMP),
    .jump_use_reg (JUMP_USE_REG),
    .branch_taken (branch_taken),
    .jump_reg_val (jump_reg_val),
    .pc_plus4     (pc_inc),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cnt_d       = cnt_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        instr_valid = 1'b1;
        // Control inputs only matter here, on the retire cycle.
        if (instr_ready) begin
          cnt_d = cnt_q + 32'd1;
          if (opcode_of(instr_q) == OpTrap) begin
            state_d = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
    // Handshake outputs are quiet for the whole reset cycle.
    if (!rst_n) begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_inc;
  assign halted      = (state_q == StHalt);
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses are queued when an
// instruction is retired and popped when the DUT issues its next request.
module tb_instr_fetch;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;
  localparam logic [5:0] OP_TRAP = 6'h11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        BRANCH;
  logic        JUMP;
  logic        JUMP_USE_REG;
  logic        branch_taken;
  logic [31:0] jump_reg_val;
  logic        halted;
  logic [31:0] retired_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_addr_q[$];

  instr_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .BRANCH       (BRANCH),
    .JUMP         (JUMP),
    .JUMP_USE_REG (JUMP_USE_REG),
    .branch_taken (branch_taken),
    .jump_reg_val (jump_reg_val),
    .halted       (halted),
    .retired_cnt  (retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] low);
    return {op, low};
  endfunction

  task automatic clear_ctrl();
    instr_ready  = 1'b0;
    BRANCH       = 1'b0;
    JUMP         = 1'b0;
    JUMP_USE_REG = 1'b0;
    branch_taken = 1'b0;
    jump_reg_val = 32'h0;
  endtask

  // One full fetch/hold/retire transaction; nxt is the required next fetch address.
  task automatic do_instr(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                          input logic br, input logic jp, input logic jr, input logic tk,
                          input logic [31:0] jrv, input logic [31:0] nxt, input bit trap);
    logic [31:0] a;
    int          n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    if (!imem_req) return;
    if (exp_addr_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    a = exp_addr_q.pop_front();
    check("fetch_addr", imem_addr, a);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("addr_hold", imem_addr, a);
      check("req_hold", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("pc_out", pc_out, a);
    check("pc_plus4", pc_plus4, a + 32'd4);
    check("req_in_hold", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      // Stray acks and control bits while not retiring must have no effect.
      instr_ready  = 1'b0;
      BRANCH       = 1'b1;
      JUMP         = 1'b1;
      JUMP_USE_REG = 1'b1;
      branch_taken = 1'b1;
      jump_reg_val = 32'hDEAD_BEE0;
      imem_ack     = 1'b1;
      imem_rdata   = $urandom;
      @(negedge clk);
      check("instr_hold", instr, word);
      check("pc_hold", pc_out, a);
      check("valid_hold", {31'b0, instr_valid}, 32'd1);
    end
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    BRANCH       = br;
    JUMP         = jp;
    JUMP_USE_REG = jr;
    branch_taken = tk;
    jump_reg_val = jrv;
    @(negedge clk);
    clear_ctrl();
    exp_cnt++;
    check("retired_cnt", retired_cnt, exp_cnt);
    if (trap) begin
      check("halted", {31'b0, halted}, 32'd1);
      check("halt_req", {31'b0, imem_req}, 32'd0);
      check("halt_valid", {31'b0, instr_valid}, 32'd0);
    end else begin
      check("not_halted", {31'b0, halted}, 32'd0);
      exp_addr_q.push_back(nxt);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    clear_ctrl();
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_instr(mk(OP_ADDI, 26'h0010005), 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
    do_instr(mk(OP_ADDI, 26'h0020007), 3, 2, 0, 0, 0, 0, 0, 32'h8, 0);
    do_instr(mk(OP_JR,   26'h0100000), 0, 0, 0, 1, 1, 0, 32'h100, 32'h100, 0);
    do_instr(mk(OP_BEQZ, 26'h000FFF8), 1, 0, 1, 0, 0, 1, 32'h55, 32'hFC, 0);
    do_instr(mk(OP_JR,   26'h0100000), 0, 1, 0, 1, 1, 0, 32'h100, 32'h100, 0);
    do_instr(mk(OP_BEQZ, 26'h000FFF8), 0, 0, 1, 0, 0, 0, 32'h55, 32'h104, 0);
    do_instr(mk(OP_JR,   26'h0100000), 0, 0, 0, 1, 1, 0, 32'h200, 32'h200, 0);
    do_instr(mk(OP_JALR, 26'h0100000), 2, 1, 0, 1, 1, 0, 32'h40, 32'h40, 0);
    // Jump beats a taken branch; the two offsets decode to different targets.
    do_instr(mk(OP_J,    26'h0010100), 0, 0, 1, 1, 0, 1, 32'h999, 32'h10144, 0);
    do_instr(mk(OP_J,    26'h3FFFFF0), 0, 0, 0, 1, 0, 0, 32'h0, 32'h10138, 0);
    do_instr(mk(OP_JR,   26'h0100000), 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    do_instr(mk(OP_ADDI, 26'h0030001), 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    do_instr(mk(OP_TRAP, 26'h0000000), 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);

    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      check("halt_stay_req", {31'b0, imem_req}, 32'd0);
      check("halt_stay", {31'b0, halted}, 32'd1);
    end
    imem_ack = 1'b0;
    check("halt_pc", pc_out, 32'h0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_req", {31'b0, imem_req}, 32'd1);
    // Reset lands in the same cycle as an ack; the ack must be dropped.
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = mk(OP_ADDI, 26'h0000123);
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    check("midrst_cnt", retired_cnt, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_halted", {31'b0, halted}, 32'd0);
    @(negedge clk);
    check("post_rst_req", {31'b0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", {31'b0, instr_valid}, 32'd0);

    exp_cnt = 0;
    exp_addr_q.delete();
    exp_addr_q.push_back(32'h0);
    do_instr(mk(OP_ADDI, 26'h0000456), 1, 1, 0, 0, 0, 0, 0, 32'h4, 0);
    @(negedge clk);
    check("final_req", {31'b0, imem_req}, 32'd1);
    if (exp_addr_q.size() != 0) check("final_addr", imem_addr, exp_addr_q.pop_front());
    else check("final_sb_empty", 32'd1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
